// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - single-transfer SRAM access sequencer between MAR/MDR and external SRAM
//
// Purpose: accepts one read or write request while idle, latches address and
// write data, walks SETUP -> ACCESS (WAIT_CYCLES) -> DONE driving the SRAM
// strobes, captures read data and pulses LD_MDR/Done on completion.
//
// Ports:
//   Clk, Reset            clock; synchronous active-high reset
//   Req, Wr, Addr, WData  request, direction, word address, write data
//   RData, LD_MDR         captured read data and its one-cycle MDR load strobe
//   Done, Busy            one-cycle completion pulse; high outside IDLE
//   SRAM_ADDR             zero-extended latched address
//   SRAM_CE_N/OE_N/WE_N   active-low SRAM strobes
//   SRAM_DQ_OUT/DQ_OE     write data and pad output enable
//   SRAM_DQ_IN            data returned from the SRAM pad

module mem_access_seq #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [15:0]       Addr,
    input  logic [15:0]       WData,
    output logic [15:0]       RData,
    output logic              LD_MDR,
    output logic              Done,
    output logic              Busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [15:0]       SRAM_DQ_OUT,
    output logic              SRAM_DQ_OE,
    input  logic [15:0]       SRAM_DQ_IN
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             wr_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_access;

    assign accept      = (state == S_IDLE) && Req;
    assign last_access = (state == S_ACCESS) && (cnt == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            wr_q        <= 1'b0;
            cnt         <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_OUT <= '0;
            RData       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q        <= Wr;
                SRAM_ADDR   <= ADDR_W'(Addr);
                SRAM_DQ_OUT <= WData;
                cnt         <= CNT_LOAD;
            end else if ((state == S_ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Sample the pad on the edge that ends the access window, when
            // the SRAM has had the full WAIT_CYCLES to drive valid data.
            if (last_access && !wr_q) begin
                RData <= SRAM_DQ_IN;
            end
        end
    end

    // Strobes decode from state and the latched direction only, so no
    // combinational path exists from Req to any output.
    always_comb begin
        state_nxt  = state;
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_DQ_OE = 1'b0;
        Done       = 1'b0;
        LD_MDR     = 1'b0;
        Busy       = 1'b1;
        case (state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Req) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                SRAM_CE_N  = 1'b0;
                SRAM_OE_N  = wr_q;
                SRAM_DQ_OE = wr_q;
                state_nxt  = S_ACCESS;
            end
            S_ACCESS: begin
                SRAM_CE_N  = 1'b0;
                SRAM_OE_N  = wr_q;
                SRAM_WE_N  = !wr_q;
                SRAM_DQ_OE = wr_q;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Done      = 1'b1;
                LD_MDR    = !wr_q;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - directed self-checking bench for mem_access_seq

module tb_mem_access_seq;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset, Req, Wr;
    logic [15:0] Addr, WData, SRAM_DQ_IN;

    logic [15:0] RData, SRAM_DQ_OUT;
    logic        LD_MDR, Done, Busy, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE;
    logic [19:0] SRAM_ADDR;

    logic [15:0] r1_rdata, r4_rdata, r1_dq, r4_dq;
    logic        r1_ld, r1_done, r1_busy, r1_ce, r1_oe, r1_we, r1_dqoe;
    logic        r4_ld, r4_done, r4_busy, r4_ce, r4_oe, r4_we, r4_dqoe;
    logic [19:0] r1_addr, r4_addr;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_rdata;

    always #5 Clk = ~Clk;

    mem_access_seq #(.WAIT_CYCLES(W), .ADDR_W(20)) u_dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
        .RData(RData), .LD_MDR(LD_MDR), .Done(Done), .Busy(Busy),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
        .SRAM_DQ_IN(SRAM_DQ_IN)
    );

    mem_access_seq #(.WAIT_CYCLES(1), .ADDR_W(20)) u_w1 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
        .RData(r1_rdata), .LD_MDR(r1_ld), .Done(r1_done), .Busy(r1_busy),
        .SRAM_ADDR(r1_addr), .SRAM_CE_N(r1_ce), .SRAM_OE_N(r1_oe),
        .SRAM_WE_N(r1_we), .SRAM_DQ_OUT(r1_dq), .SRAM_DQ_OE(r1_dqoe),
        .SRAM_DQ_IN(SRAM_DQ_IN)
    );

    mem_access_seq #(.WAIT_CYCLES(4), .ADDR_W(20)) u_w4 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
        .RData(r4_rdata), .LD_MDR(r4_ld), .Done(r4_done), .Busy(r4_busy),
        .SRAM_ADDR(r4_addr), .SRAM_CE_N(r4_ce), .SRAM_OE_N(r4_oe),
        .SRAM_WE_N(r4_we), .SRAM_DQ_OUT(r4_dq), .SRAM_DQ_OE(r4_dqoe),
        .SRAM_DQ_IN(SRAM_DQ_IN)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with all instances idle; that cycle is cycle 0.
    task automatic run_xfer(input string name, input logic wr, input logic [15:0] a,
                            input logic [15:0] wd, input logic [15:0] din, input bit inject);
        int oe_lo = 0, we_lo = 0, dqoe = 0, done_n = 0, ld_n = 0;
        int we_bad = 0, addr_bad = 0, dq_bad = 0;
        int done_c = -1, d1 = -1, d4 = -1;
        Req = 1'b1; Wr = wr; Addr = a; WData = wd; SRAM_DQ_IN = din;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (c == 1) check({name, "_busy_setup"}, Busy, 1);
            if (!SRAM_OE_N) oe_lo++;
            if (!SRAM_WE_N) begin
                we_lo++;
                if (c < 2 || c > W + 1) we_bad++;
            end
            if (SRAM_DQ_OE) begin
                dqoe++;
                if (SRAM_DQ_OUT !== wd) dq_bad++;
            end
            if (Busy && SRAM_ADDR !== {4'h0, a}) addr_bad++;
            if (Done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (LD_MDR) ld_n++;
            if (r1_done && d1 < 0) d1 = c;
            if (r4_done && d4 < 0) d4 = c;
            // Post-accept input changes must not disturb the transfer.
            if (c == 1) begin Req = 1'b0; Wr = ~wr; Addr = 16'h5555; WData = 16'h0F0F; end
            if (inject && c == 2) begin Req = 1'b1; Addr = 16'h9999; end
            if (inject && c == 3) Req = 1'b0;
        end
        if (!wr) exp_rdata = din;
        check({name, "_oe_low"},   oe_lo,  wr ? 0 : W + 1);
        check({name, "_we_low"},   we_lo,  wr ? W : 0);
        check({name, "_we_win"},   we_bad, 0);
        check({name, "_dq_oe"},    dqoe,   wr ? W + 1 : 0);
        check({name, "_dq_out"},   dq_bad, 0);
        check({name, "_addr"},     addr_bad, 0);
        check({name, "_done_cyc"}, done_c, W + 2);
        check({name, "_done_cnt"}, done_n, 1);
        check({name, "_ld_cnt"},   ld_n,   wr ? 0 : 1);
        check({name, "_rdata"},    RData,  exp_rdata);
        check({name, "_w1_done"},  d1, 3);
        check({name, "_w4_done"},  d4, 6);
    endtask

    initial begin
        int d_a, d_b, dn;
        Reset = 1'b1; Req = 1'b0; Wr = 1'b0; Addr = '0; WData = '0; SRAM_DQ_IN = '0;
        exp_rdata = 16'h0;
        repeat (3) @(negedge Clk);
        check("rst_ce",   SRAM_CE_N, 1);
        check("rst_oe",   SRAM_OE_N, 1);
        check("rst_we",   SRAM_WE_N, 1);
        check("rst_dqoe", SRAM_DQ_OE, 0);
        check("rst_addr", SRAM_ADDR, 0);
        check("rst_dq",   SRAM_DQ_OUT, 0);
        check("rst_rd",   RData, 0);
        check("rst_flags", {LD_MDR, Done, Busy}, 0);
        Reset = 1'b0;
        @(negedge Clk);

        run_xfer("read",  1'b0, 16'h1234, 16'h0000, 16'hBEEF, 1'b0);
        run_xfer("write", 1'b1, 16'h0042, 16'hA5A5, 16'h7777, 1'b0);
        run_xfer("ignore", 1'b0, 16'h1234, 16'h0000, 16'h1357, 1'b1);
        run_xfer("maxaddr", 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 1'b0);

        // Back-to-back: Req held over a read, then retargeted to a write.
        d_a = -1; d_b = -1;
        Req = 1'b1; Wr = 1'b0; Addr = 16'h1234; SRAM_DQ_IN = 16'hBEEF;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            if (Done) begin
                if (d_a < 0) d_a = c; else if (d_b < 0) d_b = c;
            end
            case (c)
                1: begin Wr = 1'b1; Addr = 16'h0042; WData = 16'hA5A5; end
                2: check("b2b_addr_hold", SRAM_ADDR, 20'h01234);
                4: check("b2b_ld1", LD_MDR, 1);
                5: begin check("b2b_idle", Busy, 0); check("b2b_rd", RData, 16'hBEEF); end
                6: begin
                    check("b2b_setup", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE}, 3'b011);
                    check("b2b_addr2", SRAM_ADDR, 20'h00042);
                    Req = 1'b0;
                end
                7, 8: check("b2b_we", SRAM_WE_N, 0);
                9: check("b2b_ld2", LD_MDR, 0);
                10: check("b2b_rd_keep", RData, 16'hBEEF);
                default: ;
            endcase
        end
        check("b2b_done1", d_a, 4);
        check("b2b_gap", d_b - d_a, 5);

        // Reset during the ACCESS phase of a write aborts it cleanly.
        dn = 0;
        Req = 1'b1; Wr = 1'b1; Addr = 16'h0042; WData = 16'h1111;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            if (c >= 3 && Done) dn++;
            if (c == 1) Req = 1'b0;
            if (c == 2) begin check("abort_access", SRAM_WE_N, 0); Reset = 1'b1; end
            if (c == 3) begin
                check("abort_strobes", {SRAM_WE_N, SRAM_CE_N, SRAM_DQ_OE}, 3'b110);
                check("abort_busy", Busy, 0);
                check("abort_done", {Done, LD_MDR}, 0);
                Reset = 1'b0;
            end
        end
        check("abort_no_done", dn, 0);
        exp_rdata = 16'h0;
        check("abort_rdata", RData, 0);
        run_xfer("post_abort", 1'b0, 16'h2468, 16'h0000, 16'hC0DE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
